// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the core and a DMA requester sharing one data_ram port.
// The core normally has priority; a DMA denied too long in a row gets a short forced burst.
module dmem_arbiter #(
  parameter int n          = 10,
  parameter int m          = 32,
  parameter int STARVE_LIM = 4,
  parameter int BURST_LEN  = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         core_req,
  input  logic         core_we,
  input  logic [n-1:0] core_addr,
  input  logic [m-1:0] core_wdata,
  output logic [m-1:0] core_rdata,
  output logic         core_stall,
  input  logic         dma_req,
  input  logic         dma_we,
  input  logic [n-1:0] dma_addr,
  input  logic [m-1:0] dma_wdata,
  output logic         dma_gnt,
  output logic [m-1:0] dma_rdata,
  output logic         dma_rvalid,
  output logic         mem_we,
  output logic [n-1:0] mem_addr,
  output logic [m-1:0] mem_wdata,
  input  logic [m-1:0] mem_rdata
);

  typedef enum logic {S_CORE, S_DMA_BURST} state_t;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIM - 1);
  localparam logic [3:0] BURST_MAX  = 4'(BURST_LEN - 1);

  state_t       state_q, state_d;
  logic [3:0]   starve_cnt_q, starve_cnt_d;
  logic [3:0]   burst_cnt_q, burst_cnt_d;
  logic [m-1:0] dma_rdata_q, dma_rdata_d;
  logic         dma_rvalid_q, dma_rvalid_d;
  logic         core_gnt;

  // Grant selection and the memory-port mux; reset suppresses every grant.
  always_comb begin
    core_gnt  = 1'b0;
    dma_gnt   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = core_addr;
    mem_wdata = core_wdata;
    if (!rst) begin
      if (state_q == S_CORE) begin
        core_gnt = core_req;
        dma_gnt  = dma_req & ~core_req;
      end else begin
        dma_gnt  = dma_req;
        core_gnt = core_req & ~dma_req;
      end
    end
    if (dma_gnt) begin
      mem_we    = dma_we;
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
    end else if (core_gnt) begin
      mem_we = core_we;
    end
  end

  assign core_stall = core_req & ~core_gnt & ~rst;
  assign core_rdata = mem_rdata;

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    burst_cnt_d  = burst_cnt_q;
    dma_rvalid_d = dma_gnt & ~dma_we;
    dma_rdata_d  = dma_rdata_q;
    if (dma_gnt && !dma_we) begin
      dma_rdata_d = mem_rdata;
    end

    if (dma_gnt || !dma_req) begin
      starve_cnt_d = 4'd0;
    end else if (state_q == S_CORE) begin
      if (starve_cnt_q == STARVE_MAX) begin
        starve_cnt_d = 4'd0;
        burst_cnt_d  = 4'd0;
        state_d      = S_DMA_BURST;
      end else begin
        starve_cnt_d = starve_cnt_q + 4'd1;
      end
    end

    // A burst ends early when the DMA goes quiet, otherwise after BURST_LEN grants.
    if (state_q == S_DMA_BURST) begin
      if (!dma_req) begin
        state_d     = S_CORE;
        burst_cnt_d = 4'd0;
      end else if (dma_gnt) begin
        if (burst_cnt_q == BURST_MAX) begin
          state_d     = S_CORE;
          burst_cnt_d = 4'd0;
        end else begin
          burst_cnt_d = burst_cnt_q + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_CORE;
      starve_cnt_q <= 4'd0;
      burst_cnt_q  <= 4'd0;
      dma_rdata_q  <= '0;
      dma_rvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      burst_cnt_q  <= burst_cnt_d;
      dma_rdata_q  <= dma_rdata_d;
      dma_rvalid_q <= dma_rvalid_d;
    end
  end

  assign dma_rdata  = dma_rdata_q;
  assign dma_rvalid = dma_rvalid_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed cycles push expectations, a negedge monitor checks them.
// A small behavioural data_ram sits on the mem_* port.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req, core_we, dma_req, dma_we;
  logic [9:0]  core_addr, dma_addr, mem_addr;
  logic [31:0] core_wdata, dma_wdata, core_rdata, dma_rdata, mem_wdata, mem_rdata;
  logic        core_stall, dma_gnt, dma_rvalid, mem_we;

  typedef struct {
    logic        gnt;
    logic        stall;
    logic        we;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic        rvalid;
    logic        chk_crd;
    logic [31:0] crd;
    int          cyc;
  } cyc_exp_t;

  cyc_exp_t    cyc_q[$];
  logic [31:0] rd_q[$];
  int          compared = 0;
  int          mismatched = 0;
  int          cyc_no = 0;
  logic        prev_dma_rd = 1'b0;
  logic [31:0] ram [0:1023] = '{default: '0};

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
  end
  assign mem_rdata = ram[mem_addr];

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_rdata(core_rdata), .core_stall(core_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // One cycle of stimulus; eg/es are the hand-computed grant and stall for that cycle.
  task automatic applyStimulus(input logic r, input logic creq, input logic cwe,
                               input logic [9:0] caddr, input logic [31:0] cwd,
                               input logic dreq, input logic dwe,
                               input logic [9:0] daddr, input logic [31:0] dwd,
                               input logic eg, input logic es, input logic [31:0] erd);
    cyc_exp_t e;
    logic     cgnt;
    @(posedge clk);
    #1;
    rst = r; core_req = creq; core_we = cwe; core_addr = caddr; core_wdata = cwd;
    dma_req = dreq; dma_we = dwe; dma_addr = daddr; dma_wdata = dwd;
    cyc_no++;
    cgnt      = creq && !es && !eg && !r;
    e.cyc     = cyc_no;
    e.gnt     = eg;
    e.stall   = es;
    e.rvalid  = prev_dma_rd;
    e.chk_crd = cgnt && !cwe;
    e.crd     = erd;
    if (eg) begin
      e.we = dwe; e.addr = daddr; e.wdata = dwd;
    end else begin
      e.we = cgnt && cwe; e.addr = caddr; e.wdata = cwd;
    end
    cyc_q.push_back(e);
    prev_dma_rd = eg && !dwe && !r;
    if (eg && !dwe && !r) rd_q.push_back(erd);
  endtask

  // Core reads addr 96 (holding 2) while the DMA writes addr 60.
  task automatic contend(input logic r, input logic eg, input logic es);
    applyStimulus(r, 1, 0, 10'd96, 32'h0, 1, 1, 10'd60, 32'h100 + 32'(cyc_no), eg, es, 32'd2);
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 10'd7, 32'h0, 0, 0, 10'd0, 32'h0, 0, 0, 32'h0);
  endtask

  task automatic checkOutput(input cyc_exp_t e);
    logic bad;
    compared++;
    bad = (dma_gnt !== e.gnt) || (core_stall !== e.stall) || (mem_we !== e.we) ||
          (mem_addr !== e.addr) || (mem_wdata !== e.wdata) || (dma_rvalid !== e.rvalid) ||
          (e.chk_crd && (core_rdata !== e.crd));
    if (bad) begin
      mismatched++;
      $display("[TB] FAIL cycle%0d: got gnt=%b stall=%b we=%b addr=%0d wdata=%h rvalid=%b crd=%h ; required gnt=%b stall=%b we=%b addr=%0d wdata=%h rvalid=%b crd=%h(chk=%b)",
               e.cyc, dma_gnt, core_stall, mem_we, mem_addr, mem_wdata, dma_rvalid, core_rdata,
               e.gnt, e.stall, e.we, e.addr, e.wdata, e.rvalid, e.crd, e.chk_crd);
    end
  endtask

  always @(negedge clk) begin
    if (cyc_q.size() > 0) checkOutput(cyc_q.pop_front());
    if (dma_rvalid === 1'b1) begin
      compared++;
      if (rd_q.size() == 0) begin
        mismatched++;
        $display("[TB] FAIL dma_read: got rvalid=1 rdata=%h ; required no pending read", dma_rdata);
      end else begin
        logic [31:0] exp_rd;
        exp_rd = rd_q.pop_front();
        if (dma_rdata !== exp_rd) begin
          mismatched++;
          $display("[TB] FAIL dma_read: got rdata=%h ; required %h", dma_rdata, exp_rd);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; core_req = 0; core_we = 0; core_addr = 0; core_wdata = 0;
    dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
    repeat (2) @(posedge clk);

    // Reset holds every grant low even with both requesters asking to write.
    applyStimulus(1, 1, 1, 10'd5, 32'h11, 1, 1, 10'd6, 32'h22, 0, 0, 0);
    applyStimulus(1, 1, 1, 10'd5, 32'h11, 1, 1, 10'd6, 32'h22, 0, 0, 0);

    // Core-only traffic, then DMA use of idle slots including write-then-read.
    applyStimulus(0, 1, 1, 10'd92, 32'd4, 0, 0, 10'd0, 32'h0, 0, 0, 0);
    applyStimulus(0, 1, 1, 10'd96, 32'd2, 0, 0, 10'd0, 32'h0, 0, 0, 0);
    applyStimulus(0, 1, 0, 10'd96, 32'h0, 0, 0, 10'd0, 32'h0, 0, 0, 32'd2);
    applyStimulus(0, 0, 0, 10'd3, 32'h0, 1, 0, 10'd92, 32'h0, 1, 0, 32'd4);
    applyStimulus(0, 0, 0, 10'd3, 32'h0, 1, 1, 10'd50, 32'hAA, 1, 0, 0);
    applyStimulus(0, 0, 0, 10'd3, 32'h0, 1, 0, 10'd50, 32'h0, 1, 0, 32'hAA);
    idle();

    // Sustained contention: four denials, two forced DMA grants, core again.
    for (int i = 0; i < 4; i++) contend(0, 0, 0);
    for (int i = 0; i < 2; i++) contend(0, 1, 1);
    contend(0, 0, 0);
    idle();

    // Burst cut short by dma_req dropping; the next forced burst needs 4 fresh denials.
    for (int i = 0; i < 4; i++) contend(0, 0, 0);
    contend(0, 1, 1);
    applyStimulus(0, 1, 0, 10'd96, 32'h0, 0, 0, 10'd60, 32'h0, 0, 0, 32'd2);
    for (int i = 0; i < 4; i++) contend(0, 0, 0);
    for (int i = 0; i < 2; i++) contend(0, 1, 1);
    idle();

    // Reset in the first burst cycle aborts it; counting restarts from zero.
    for (int i = 0; i < 4; i++) contend(0, 0, 0);
    contend(1, 0, 0);
    for (int i = 0; i < 4; i++) contend(0, 0, 0);
    for (int i = 0; i < 2; i++) contend(0, 1, 1);
    contend(0, 0, 0);
    idle();

    // A one-cycle DMA gap after three denials clears the starvation count.
    for (int i = 0; i < 3; i++) contend(0, 0, 0);
    applyStimulus(0, 1, 0, 10'd96, 32'h0, 0, 0, 10'd60, 32'h0, 0, 0, 32'd2);
    for (int i = 0; i < 4; i++) contend(0, 0, 0);
    for (int i = 0; i < 2; i++) contend(0, 1, 1);
    contend(0, 0, 0);
    idle();

    repeat (3) @(negedge clk);
    compared++;
    if (cyc_q.size() != 0 || rd_q.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL drain: got %0d cycle / %0d read expectations left ; required 0 / 0",
               cyc_q.size(), rd_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter n, default 10, data-memory address width.
REQ-002 SHALL have parameter m, default 32, data word width.
REQ-003 SHALL have parameter STARVE_LIM, default 4, consecutive contested DMA denials before a forced DMA burst (legal range 1..15).
REQ-004 SHALL have parameter BURST_LEN, default 2, maximum cycles in one forced DMA burst (legal range 1..15).
REQ-005 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-007 SHALL have ports core_req in 1, core_we in 1, core_addr in n, core_wdata in m; core access request.
REQ-008 SHALL have ports core_rdata out m, the combinational read data, and core_stall out 1, meaning the core access was not served this cycle.
REQ-009 SHALL have ports dma_req in 1, dma_we in 1, dma_addr in n, dma_wdata in m; second-requester access request.
REQ-010 SHALL have port dma_gnt out 1, meaning the DMA access is performed this cycle.
REQ-011 SHALL have ports dma_rdata out m, the registered read data, and dma_rvalid out 1, meaning dma_rdata is valid.
REQ-012 SHALL have ports mem_we out 1, mem_addr out n, mem_wdata out m and mem_rdata in m, connecting to data_ram, which has a combinational read and a write on the rising edge.

Function
REQ-013 SHALL implement a two-state FSM: S_CORE (reset state) and S_DMA_BURST.
REQ-014 In S_CORE, SHALL grant the core whenever core_req=1 and grant the DMA when dma_req=1 and core_req=0 (idle slot).
REQ-015 In S_DMA_BURST, SHALL grant the DMA whenever dma_req=1 and grant the core only when dma_req=0.
REQ-016 SHALL grant at most one requester per cycle; dma_gnt and core_stall are combinational from state, core_req and dma_req.
REQ-017 SHALL drive core_stall = core_req AND NOT core granted; core_stall SHALL be 0 when core_req=0.
REQ-018 SHALL mux mem_addr, mem_wdata and mem_we from the granted requester; with no grant, mem_we=0 and mem_addr/mem_wdata = core values.
REQ-019 SHALL keep a starve_cnt (4 bits): +1 on each cycle in S_CORE with dma_req=1 and dma_gnt=0; cleared on any dma_gnt=1 cycle or when dma_req=0.
REQ-020 In S_CORE, when starve_cnt = STARVE_LIM-1 and the DMA is denied this cycle, SHALL move to S_DMA_BURST next cycle, clear starve_cnt and load burst_cnt=0.
REQ-021 In S_DMA_BURST, burst_cnt SHALL increment on each dma_gnt=1 cycle.
REQ-022 SHALL return to S_CORE when dma_req=0, or after the dma_gnt cycle in which burst_cnt = BURST_LEN-1.
REQ-023 SHALL drive core_rdata = mem_rdata combinationally in every cycle; it is meaningful only when the core is granted and core_we=0.
REQ-024 On a granted DMA read (dma_gnt=1, dma_we=0), SHALL register mem_rdata into dma_rdata and assert dma_rvalid for exactly the next cycle, a 1-cycle latency.
REQ-025 SHALL keep dma_rvalid at 0 after DMA writes and non-granted cycles, and SHALL hold dma_rdata until the next granted read.
REQ-026 SHALL treat a DMA write-then-read of the same address in consecutive grants as returning the new data (write at edge N, read at cycle N+1).

Reset
REQ-027 While rst=1, SHALL force: state=S_CORE, starve_cnt=0, burst_cnt=0, dma_rvalid=0, dma_rdata=0.
REQ-028 While rst=1, SHALL force: dma_gnt=0, core_stall=0, mem_we=0, regardless of requests.
REQ-029 An assertion of rst in the middle of a burst SHALL abort the burst; the first cycle after rst=0 SHALL be in S_CORE with counters 0.

Verification
REQ-030 Core only: core_req=1, core_we=1, addr 96, data 2 -> mem_we=1, mem_addr=96, mem_wdata=2, core_stall=0, dma_gnt=0.
REQ-031 Idle slot: core_req=0, dma_req=1, read at addr 92 holding 4 -> dma_gnt=1 same cycle; next cycle dma_rvalid=1, dma_rdata=4.
REQ-032 Contention (defaults): core_req=1 and dma_req=1 from cycle 1 -> cycles 1-4 core granted and starve_cnt reaches 3; cycles 5-6 dma_gnt=1, core_stall=1; cycle 7 core granted, core_stall=0.
REQ-033 Early burst exit: forced burst starts and dma_req drops after 1 grant -> next cycle core granted, state S_CORE, starve_cnt=0.
REQ-034 Reset mid-burst: rst=1 during cycle 5 of REQ-032 -> dma_gnt=0, mem_we=0, dma_rvalid=0; after release, contention needs 4 new denials before the DMA is forced.
REQ-035 Counter clear: dma_req deasserted for 1 cycle after 3 contested denials -> starve_cnt=0 and the forced burst is delayed by 4 more contested cycles.
